alu_host_sequencer: RTL and testbench

ALU_HOST_SEQUENCER -- requirements
Module: alu_host_sequencer

---
 rtl/alu_host_sequencer_if.sv | 33 +++
 rtl/alu_host_sequencer.sv | 72 +++++++
 tb/tb_alu_host_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_host_sequencer_if.sv
// alu_host_sequencer_if: host operand/command port plus the UART transmit/receive handshakes.
interface alu_host_sequencer_if #(
    parameter int ancho_dato = 8,
    parameter int ancho_op   = 6
);
    logic                  i_start;
    logic [ancho_dato-1:0] i_dato_A;
    logic [ancho_dato-1:0] i_dato_B;
    logic [ancho_op-1:0]   i_dato_Op;
    logic                  senial_finTransmicion;
    logic                  senial_lecturaReceptor;
    logic [ancho_dato-1:0] datoEntrada_receptor;
    logic                  comienzo_transmicion;
    logic [ancho_dato-1:0] datoSalida_transmisor;
    logic [ancho_dato-1:0] o_resultado;
    logic                  o_valid;
    logic                  o_busy;
    logic                  o_timeout;

    modport master (
        input  i_start, i_dato_A, i_dato_B, i_dato_Op,
               senial_finTransmicion, senial_lecturaReceptor, datoEntrada_receptor,
        output comienzo_transmicion, datoSalida_transmisor,
               o_resultado, o_valid, o_busy, o_timeout
    );

    modport slave (
        output i_start, i_dato_A, i_dato_B, i_dato_Op,
               senial_finTransmicion, senial_lecturaReceptor, datoEntrada_receptor,
        input  comienzo_transmicion, datoSalida_transmisor,
               o_resultado, o_valid, o_busy, o_timeout
    );
endinterface

// File: rtl/alu_host_sequencer.sv
// alu_host_sequencer: sends A, B and Op bytes over a UART, then waits (bounded) for the ALU result byte.
module alu_host_sequencer #(
    parameter int ancho_dato     = 8,
    parameter int ancho_op       = 6,
    parameter int TIMEOUT_CICLOS = 1000000
) (
    input logic                  clk,
    input logic                  reset,
    alu_host_sequencer_if.master bus
);
    localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B, SEND_OP, WAIT_OP, WAIT_RESULT, DONE
    } state_t;

    state_t                state, next;
    logic [ancho_dato-1:0] reg_a, reg_b, resultado;
    logic [ancho_op-1:0]   reg_op;
    logic [CW-1:0]         cnt;
    logic                  terminal;

    assign terminal = cnt == TERMINAL;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            reg_a     <= '0;
            reg_b     <= '0;
            reg_op    <= '0;
            cnt       <= '0;
            resultado <= '0;
        end else begin
            state <= next;
            if (state == IDLE && bus.i_start) begin
                reg_a  <= bus.i_dato_A;
                reg_b  <= bus.i_dato_B;
                reg_op <= bus.i_dato_Op;
            end
            // counter idles at zero, so it is already cleared on entry to the result wait
            cnt <= (state == WAIT_RESULT) ? cnt + CW'(1) : '0;
            if (state == WAIT_RESULT && bus.senial_lecturaReceptor)
                resultado <= bus.datoEntrada_receptor;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:        next = bus.i_start ? SEND_A : IDLE;
            SEND_A:      next = WAIT_A;
            WAIT_A:      next = bus.senial_finTransmicion ? SEND_B : WAIT_A;
            SEND_B:      next = WAIT_B;
            WAIT_B:      next = bus.senial_finTransmicion ? SEND_OP : WAIT_B;
            SEND_OP:     next = WAIT_OP;
            WAIT_OP:     next = bus.senial_finTransmicion ? WAIT_RESULT : WAIT_OP;
            WAIT_RESULT: next = bus.senial_lecturaReceptor ? DONE : (terminal ? IDLE : WAIT_RESULT);
            DONE:        next = IDLE;
            default:     next = IDLE;
        endcase
    end

    assign bus.comienzo_transmicion  = state == SEND_A || state == SEND_B || state == SEND_OP;
    assign bus.datoSalida_transmisor = (state == SEND_A || state == WAIT_A) ? reg_a :
                                       (state == SEND_B || state == WAIT_B) ? reg_b :
                                       (state == SEND_OP || state == WAIT_OP) ? ancho_dato'(reg_op) : '0;
    assign bus.o_resultado           = resultado;
    assign bus.o_valid               = state == DONE;
    assign bus.o_busy                = state != IDLE;
    assign bus.o_timeout             = state == WAIT_RESULT && terminal && !bus.senial_lecturaReceptor;
endmodule

// File: tb/tb_alu_host_sequencer.sv
// tb_alu_host_sequencer: directed transactions checked every cycle against a byte-queue protocol model.
module tb_alu_host_sequencer;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_host_sequencer_if #(.ancho_dato(8), .ancho_op(6)) bus ();
    alu_host_sequencer #(.ancho_dato(8), .ancho_op(6), .TIMEOUT_CICLOS(TO)) dut (
        .clk(clk), .reset(rst_n), .bus(bus)
    );

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int valid_cnt = 0, to_cnt = 0, valid_cyc = 0, to_cyc = 0, start_cyc = 0, fin_cyc = 0;
    logic [7:0] tx_log[$];

    // protocol model: bytes queued for sending, one byte in flight, then a bounded result wait
    bit         m_active = 0, m_launch = 0, m_inflight = 0, m_done = 0;
    int         m_wait = -1;
    logic [7:0] m_cur = 0, m_res = 0;
    logic [7:0] m_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_launch = 0; m_inflight = 0; m_done = 0;
            m_wait = -1; m_cur = 0; m_res = 0; m_q.delete();
        end else if (m_done) begin
            m_done = 0; m_active = 0;
        end else if (!m_active) begin
            if (bus.i_start) begin
                m_q = '{bus.i_dato_A, bus.i_dato_B, {2'b00, bus.i_dato_Op}};
                m_active = 1;
                m_cur = m_q.pop_front(); m_launch = 1; m_inflight = 1;
            end
        end else if (m_launch) begin
            m_launch = 0;
        end else if (m_inflight) begin
            if (bus.senial_finTransmicion) begin
                m_inflight = 0;
                if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front(); m_launch = 1; m_inflight = 1;
                end else m_wait = 0;
            end
        end else if (m_wait >= 0) begin
            if (bus.senial_lecturaReceptor) begin
                m_res = bus.datoEntrada_receptor; m_wait = -1; m_done = 1;
            end else if (m_wait == TO - 1) begin
                m_wait = -1; m_active = 0;
            end else m_wait++;
        end
    end

    always @(negedge clk) begin
        chk("busy", bus.o_busy, m_active);
        chk("start_tx", bus.comienzo_transmicion, m_launch);
        chk("tx_byte", bus.datoSalida_transmisor, m_inflight ? m_cur : 8'h00);
        chk("valid", bus.o_valid, m_done);
        chk("timeout", bus.o_timeout, (m_wait == TO - 1) && !bus.senial_lecturaReceptor);
        chk("result", bus.o_resultado, m_res);
        if (bus.comienzo_transmicion) tx_log.push_back(bus.datoSalida_transmisor);
        if (bus.o_valid) begin valid_cnt++; valid_cyc = cyc; end
        if (bus.o_timeout) begin to_cnt++; to_cyc = cyc; end
    end

    task automatic wait_launch();
        bit seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = bus.comienzo_transmicion;
        end
        chk("launch_seen", seen, 1);
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                       input int d, input int r, input bit give, input logic [7:0] res, input bit spur);
        tx_log.delete(); valid_cnt = 0; to_cnt = 0;
        @(posedge clk); #1;
        bus.i_start = 1; bus.i_dato_A = a; bus.i_dato_B = b; bus.i_dato_Op = op; start_cyc = cyc;
        @(posedge clk); #1;
        bus.i_start = 0; bus.i_dato_A = 8'hFF; bus.i_dato_B = 8'hFF; bus.i_dato_Op = 6'h00;
        for (int i = 0; i < 3; i++) begin
            wait_launch();
            if (spur && i == 1) begin
                @(posedge clk); #1;
                bus.i_start = 1; bus.senial_lecturaReceptor = 1; bus.datoEntrada_receptor = 8'hEE;
                @(posedge clk); #1;
                bus.i_start = 0; bus.senial_lecturaReceptor = 0;
                repeat (d - 2) @(posedge clk);
            end else repeat (d) @(posedge clk);
            #1 bus.senial_finTransmicion = 1; fin_cyc = cyc;
            @(posedge clk); #1 bus.senial_finTransmicion = 0;
        end
        if (give) begin
            repeat (r) begin @(posedge clk); #1; end
            bus.senial_lecturaReceptor = 1; bus.datoEntrada_receptor = res;
            @(posedge clk); #1 bus.senial_lecturaReceptor = 0;
            repeat (2) @(posedge clk); #1;
        end else begin
            repeat (TO + 3) @(posedge clk); #1;
        end
        chk("tx_count", tx_log.size(), 3);
        if (tx_log.size() == 3) begin
            chk("byte_a", tx_log[0], a);
            chk("byte_b", tx_log[1], b);
            chk("byte_op", tx_log[2], {2'b00, op});
        end
        chk("valid_pulses", valid_cnt, give ? 1 : 0);
        chk("timeout_pulses", to_cnt, give ? 0 : 1);
        chk("result_after", bus.o_resultado, res);
        chk("busy_after", bus.o_busy, 0);
        if (!give) chk("timeout_delay", to_cyc - fin_cyc, TO);
    endtask

    initial begin
        bus.i_start = 0; bus.i_dato_A = 0; bus.i_dato_B = 0; bus.i_dato_Op = 0;
        bus.senial_finTransmicion = 0; bus.senial_lecturaReceptor = 0; bus.datoEntrada_receptor = 0;
        #1 rst_n = 0;
        repeat (2) @(posedge clk); #1;
        chk("rst_result", bus.o_resultado, 8'h00);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_tx", bus.datoSalida_transmisor, 8'h00);
        @(negedge clk) rst_n = 1;

        txn(8'h05, 8'h03, 6'h20, 10, 5, 1, 8'h08, 0);
        txn(8'hA1, 8'hB2, 6'h3F, 2, 1, 1, 8'hC3, 0);
        txn(8'h07, 8'h09, 6'h01, 1, 0, 1, 8'h10, 0);
        chk("min_latency", valid_cyc - start_cyc, 8);
        txn(8'h22, 8'h33, 6'h04, 1, 0, 0, 8'h10, 0);
        txn(8'h44, 8'h55, 6'h06, 3, TO - 1, 1, 8'h99, 0);
        txn(8'h66, 8'h77, 6'h2A, 10, 2, 1, 8'h13, 1);

        @(posedge clk); #1;
        bus.i_start = 1; bus.i_dato_A = 8'hC5; bus.i_dato_B = 8'h3C; bus.i_dato_Op = 6'h15;
        @(posedge clk); #1 bus.i_start = 0;
        for (int i = 0; i < 2; i++) begin
            wait_launch();
            @(posedge clk); #1 bus.senial_finTransmicion = 1;
            @(posedge clk); #1 bus.senial_finTransmicion = 0;
        end
        wait_launch();
        @(posedge clk); @(posedge clk); #3 rst_n = 0;
        #1;
        chk("arst_start_tx", bus.comienzo_transmicion, 0);
        chk("arst_tx", bus.datoSalida_transmisor, 8'h00);
        chk("arst_result", bus.o_resultado, 8'h00);
        chk("arst_valid", bus.o_valid, 0);
        chk("arst_busy", bus.o_busy, 0);
        chk("arst_timeout", bus.o_timeout, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        txn(8'h11, 8'h22, 6'h33, 2, 0, 1, 8'h44, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end
endmodule
